cpu_boot_sequencer: RTL

Host-side controller that owns the CPU core's load and run ports.
- Holds the core in reset.
- Streams a program image into instruction memory, then a data image into data memory, using the core's inst_data/address/write_instruction/write_data inputs.
- Releases reset for a programmed number of cycles, then freezes the core and reports completion.
- Sits between the host/testbench word stream and the CPU top.

---
 rtl/cpu_boot_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cpu_boot_sequencer.sv
// cpu_boot_sequencer: owns the CPU core's reset and memory load ports.
// Holds the core in reset, streams an instruction image and then a data
// image into the core's memories, releases reset for a programmed number
// of cycles, then freezes the core again and reports completion.
module cpu_boot_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RUN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   inst_count,
  input  logic [ADDR_W:0]   data_count,
  input  logic [RUN_W-1:0]  run_cycles,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              cpu_rst,
  output logic [DATA_W-1:0] cpu_inst_data,
  output logic [ADDR_W-1:0] cpu_address,
  output logic              cpu_write_instruction,
  output logic              cpu_write_data,
  output logic              busy,
  output logic              done,
  output logic [RUN_W-1:0]  cycle_count
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_I,
    S_LOAD_D,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  addr, addr_nxt;
  logic [CNT_W-1:0]  inst_lim, inst_lim_nxt;
  logic [CNT_W-1:0]  data_lim, data_lim_nxt;
  logic [RUN_W-1:0]  run_lim, run_lim_nxt;
  logic [RUN_W-1:0]  cycle_cnt, cycle_cnt_nxt;
  logic [CNT_W-1:0]  inst_clamp, data_clamp;
  logic [DATA_W-1:0] data_hold;
  logic              loading;

  // Counts beyond the memory depth are limited so a load never wraps.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
    return (c > DEPTH) ? DEPTH : c;
  endfunction

  // First non-empty phase of a job; empty segments are skipped entirely.
  function automatic state_t pick_entry(input logic [CNT_W-1:0] ic,
                                        input logic [CNT_W-1:0] dc,
                                        input logic [RUN_W-1:0] rc);
    if (ic != '0)      return S_LOAD_I;
    else if (dc != '0) return S_LOAD_D;
    else if (rc != '0) return S_RUN;
    else               return S_DONE;
  endfunction

  assign inst_clamp = clamp_count(inst_count);
  assign data_clamp = clamp_count(data_count);
  assign loading    = (state == S_LOAD_I) || (state == S_LOAD_D);

  // Next-state, counter and strobe logic; abort overrides everything.
  always_comb begin
    state_nxt             = state;
    addr_nxt              = addr;
    inst_lim_nxt          = inst_lim;
    data_lim_nxt          = data_lim;
    run_lim_nxt           = run_lim;
    cycle_cnt_nxt         = cycle_cnt;
    in_ready              = 1'b0;
    cpu_write_instruction = 1'b0;
    cpu_write_data        = 1'b0;
    if (abort) begin
      state_nxt = S_IDLE;
      addr_nxt  = '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            inst_lim_nxt  = inst_clamp;
            data_lim_nxt  = data_clamp;
            run_lim_nxt   = run_cycles;
            addr_nxt      = '0;
            cycle_cnt_nxt = '0;
            state_nxt     = pick_entry(inst_clamp, data_clamp, run_cycles);
          end
        end
        S_LOAD_I: begin
          in_ready              = 1'b1;
          cpu_write_instruction = in_valid;
          if (in_valid) begin
            if (addr == inst_lim - CNT_ONE) begin
              addr_nxt  = '0;
              state_nxt = pick_entry('0, data_lim, run_lim);
            end else begin
              addr_nxt = addr + CNT_ONE;
            end
          end
        end
        S_LOAD_D: begin
          in_ready       = 1'b1;
          cpu_write_data = in_valid;
          if (in_valid) begin
            if (addr == data_lim - CNT_ONE) begin
              addr_nxt  = '0;
              state_nxt = pick_entry('0, '0, run_lim);
            end else begin
              addr_nxt = addr + CNT_ONE;
            end
          end
        end
        S_RUN: begin
          if (cycle_cnt != run_lim) cycle_cnt_nxt = cycle_cnt + RUN_ONE;
          if (cycle_cnt == run_lim - RUN_ONE) state_nxt = S_DONE;
        end
        default: begin
          state_nxt = S_IDLE;
          addr_nxt  = '0;
        end
      endcase
    end
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      inst_lim  <= '0;
      data_lim  <= '0;
      run_lim   <= '0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      inst_lim  <= inst_lim_nxt;
      data_lim  <= data_lim_nxt;
      run_lim   <= run_lim_nxt;
      cycle_cnt <= cycle_cnt_nxt;
    end
  end

  // Keeps the last written word so the core's data input is quiet between loads.
  always_ff @(posedge clk) begin
    if (cpu_write_instruction || cpu_write_data) data_hold <= in_data;
  end

  assign cpu_inst_data = loading ? in_data : data_hold;
  assign cpu_address   = addr[ADDR_W-1:0];
  assign cpu_rst       = (state != S_RUN);
  assign busy          = loading || (state == S_RUN);
  assign done          = (state == S_DONE);
  assign cycle_count   = cycle_cnt;

endmodule
